mvm_ctrl: RTL and testbench

- Control FSM for the matrix-vector multiply datapath (a matrix memory, x memory, MAC/accumulator, y memory).
- Decodes the loadMatrix / loadVector / start command pulses and sequences the datapath.
- Generates memory write/read addresses and enables, MAC framing, y write-back, the done pulse and the output drain sequence.
- Owns no data storage; data_in and data_out pass through the datapath only.

---
 rtl/mvm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mvm_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mvm_ctrl.sv
// mvm_ctrl: command decode and sequencing for the matrix-vector multiply datapath.
// Loads A (row-major) and x, streams A*x through the MAC, writes y back and
// drains y through the datapath's synchronous-read y memory.
// Optional build macro MVM_CTRL_CMD_ERR_EN adds the cmd_err pulse output.
module mvm_ctrl #(
   parameter int M       = 32,
   parameter int MAC_LAT = 1,
   parameter int AW_A    = $clog2(M*M),
   parameter int AW_X    = $clog2(M)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            loadMatrix,
   input  logic            loadVector,
   input  logic            start,
   output logic            a_we,
   output logic [AW_A-1:0] a_addr,
   output logic            x_we,
   output logic [AW_X-1:0] x_addr,
   output logic            mac_valid,
   output logic            mac_first,
   output logic            y_we,
   output logic [AW_X-1:0] y_addr,
   output logic            done,
   output logic            out_valid
`ifdef MVM_CTRL_CMD_ERR_EN
   ,
   output logic            cmd_err
`endif
);

   localparam logic [AW_A-1:0] LAST_A    = AW_A'(M*M-1);
   localparam logic [AW_X-1:0] LAST_X    = AW_X'(M-1);
   localparam logic [AW_A-1:0] DRAIN_END = AW_A'(M);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, FLUSH, DRAIN} state_t;

   state_t                    state, state_nxt;
   logic [AW_A-1:0]           cnt, cnt_nxt;   // A address / drain step
   logic [AW_X-1:0]           k, k_nxt;       // column (x address)
   logic [AW_X-1:0]           j, j_nxt;       // row being issued
   logic                      issue;
   // Row-end marker and row index, stage 0 aligned with mac_valid,
   // stage MAC_LAT aligned with the accumulator result.
   logic [MAC_LAT:0]          last_pipe;
   logic [MAC_LAT:0][AW_X-1:0] row_pipe;

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         k     <= '0;
         j     <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         k     <= k_nxt;
         j     <= j_nxt;
      end
   end

   // Next-state, counter update and datapath control decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k;
      j_nxt     = j;
      a_we      = 1'b0;
      a_addr    = '0;
      x_we      = 1'b0;
      x_addr    = '0;
      issue     = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      y_we      = last_pipe[MAC_LAT];
      y_addr    = last_pipe[MAC_LAT] ? row_pipe[MAC_LAT] : '0;
      case (state)
         IDLE: begin
            if (loadMatrix)      state_nxt = LOAD_A;
            else if (loadVector) state_nxt = LOAD_X;
            else if (start)      state_nxt = COMPUTE;
         end
         LOAD_A: begin
            a_we   = 1'b1;
            a_addr = cnt;
            if (cnt == LAST_A) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LOAD_X: begin
            x_we   = 1'b1;
            x_addr = k;
            if (k == LAST_X) begin
               k_nxt     = '0;
               state_nxt = IDLE;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         COMPUTE: begin
            issue  = 1'b1;
            a_addr = cnt;
            x_addr = k;
            if (k == LAST_X) begin
               k_nxt = '0;
               j_nxt = (j == LAST_X) ? '0 : j + 1'b1;
            end else begin
               k_nxt = k + 1'b1;
            end
            if (cnt == LAST_A) begin
               cnt_nxt   = '0;
               state_nxt = FLUSH;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         FLUSH: begin
            // the row M-1 write-back is the last one in flight
            if (last_pipe[MAC_LAT] && row_pipe[MAC_LAT] == LAST_X)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // step 0 is the done cycle; steps 1..M present y[step-1]
            done      = (cnt == '0);
            out_valid = (cnt != '0);
            y_addr    = (cnt < DRAIN_END) ? cnt[AW_X-1:0] : '0;
            if (cnt == DRAIN_END) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // MAC framing follows the 1-cycle memory read; row ends ride a MAC_LAT delay line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_valid <= 1'b0;
         mac_first <= 1'b0;
         last_pipe <= '0;
         row_pipe  <= '0;
      end else begin
         mac_valid    <= issue;
         mac_first    <= issue && (k == '0);
         last_pipe[0] <= issue && (k == LAST_X);
         row_pipe[0]  <= j;
         for (int i = 1; i <= MAC_LAT; i++) begin
            last_pipe[i] <= last_pipe[i-1];
            row_pipe[i]  <= row_pipe[i-1];
         end
      end
   end

`ifdef MVM_CTRL_CMD_ERR_EN
   logic any_cmd, multi_cmd;
   assign any_cmd   = loadMatrix | loadVector | start;
   assign multi_cmd = (loadMatrix & loadVector) | (loadMatrix & start) | (loadVector & start);

   // Flag commands that arrive while busy or collide in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cmd_err <= 1'b0;
      else       cmd_err <= (state != IDLE) ? any_cmd : multi_cmd;
   end
`endif

endmodule

// File: tb/tb_mvm_ctrl.sv
// tb_mvm_ctrl: directed bench for mvm_ctrl (M=32) with a behavioural datapath
// around the MAC_LAT=1 instance; a MAC_LAT=3 instance shares the stimulus.
module tb_mvm_ctrl;
   localparam int M = 32;

   logic clk = 1'b0, reset = 1'b1;
   logic loadMatrix = 1'b0, loadVector = 1'b0, start = 1'b0;

   logic       a_we, x_we, mac_valid, mac_first, y_we, done, out_valid;
   logic [9:0] a_addr;
   logic [4:0] x_addr, y_addr;
   logic       a_we2, x_we2, mac_valid2, mac_first2, y_we2, done2, out_valid2;
   logic [9:0] a_addr2;
   logic [4:0] x_addr2, y_addr2;
`ifdef MVM_CTRL_CMD_ERR_EN
   logic cmd_err, cmd_err2;
`endif

   int n_chk = 0, n_pass = 0;
   int yexp [M];

   mvm_ctrl #(.M(M), .MAC_LAT(1)) dut (
      .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
      .a_we(a_we), .a_addr(a_addr), .x_we(x_we), .x_addr(x_addr),
      .mac_valid(mac_valid), .mac_first(mac_first), .y_we(y_we), .y_addr(y_addr),
      .done(done), .out_valid(out_valid)
`ifdef MVM_CTRL_CMD_ERR_EN
      , .cmd_err(cmd_err)
`endif
   );

   mvm_ctrl #(.M(M), .MAC_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
      .a_we(a_we2), .a_addr(a_addr2), .x_we(x_we2), .x_addr(x_addr2),
      .mac_valid(mac_valid2), .mac_first(mac_first2), .y_we(y_we2), .y_addr(y_addr2),
      .done(done2), .out_valid(out_valid2)
`ifdef MVM_CTRL_CMD_ERR_EN
      , .cmd_err(cmd_err2)
`endif
   );

   always #5 clk = ~clk;

   logic [26:0] outs1, outs2;
   assign outs1 = {a_we, a_addr, x_we, x_addr, mac_valid, mac_first, y_we, y_addr, done, out_valid};
   assign outs2 = {a_we2, a_addr2, x_we2, x_addr2, mac_valid2, mac_first2, y_we2, y_addr2, done2, out_valid2};

   // Behavioural datapath: A/x memories, 1-cycle read, MAC_LAT=1 accumulator, y memory
   logic [31:0] data_in = '0, data_out, a_q, x_q, acc;
   logic [31:0] amem [M*M];
   logic [31:0] xmem [M];
   logic [31:0] ymem [M];
   always @(posedge clk) begin
      if (a_we) amem[a_addr] <= data_in;
      if (x_we) xmem[x_addr] <= data_in;
      a_q <= amem[a_addr];
      x_q <= xmem[x_addr];
      if (mac_valid) acc <= mac_first ? a_q * x_q : acc + a_q * x_q;
      if (y_we) ymem[y_addr] <= acc;
      data_out <= ymem[y_addr];
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic load_x(input bit with_start);
      int err = 0, xw = 0, mv = 0, ce = 0;
      @(posedge clk) #1 loadVector = 1'b1;
      @(posedge clk) #1 loadVector = 1'b0;
      for (int i = 0; i < M; i++) begin
         data_in = 32'(i);
         start   = with_start && (i == 5);
         @(negedge clk);
         if (!(x_we && x_addr == 5'(i))) err++;
         xw += int'(x_we);
         mv += int'(mac_valid | mac_valid2);
`ifdef MVM_CTRL_CMD_ERR_EN
         ce += int'(cmd_err);
`endif
         @(posedge clk) #1;
      end
      start = 1'b0;
      repeat (5) begin
         @(negedge clk);
         xw += int'(x_we);
         mv += int'(mac_valid | mac_valid2);
      end
      chk("ldx_addr", err, 0);
      chk("ldx_we_cnt", xw, M);
      chk("ldx_no_mac", mv, 0);
`ifdef MVM_CTRL_CMD_ERR_EN
      chk("ldx_cmd_err", ce, with_start ? 1 : 0);
`endif
   endtask

   // mode 0: identity, mode 1: all ones
   task automatic load_a(input int mode, input bit with_start);
      int err = 0, aw = 0, mv = 0, ce = 0;
      @(posedge clk) #1 loadMatrix = 1'b1; start = with_start;
      @(posedge clk) #1 loadMatrix = 1'b0; start = 1'b0;
      for (int i = 0; i < M*M; i++) begin
         data_in = (mode == 1) ? 32'd1 : ((i / M == i % M) ? 32'd1 : 32'd0);
         @(negedge clk);
         if (!(a_we && a_addr == 10'(i))) err++;
         aw += int'(a_we);
         mv += int'(mac_valid);
`ifdef MVM_CTRL_CMD_ERR_EN
         ce += int'(cmd_err);
`endif
         @(posedge clk) #1;
      end
      repeat (5) begin
         @(negedge clk);
         aw += int'(a_we);
         mv += int'(mac_valid);
      end
      chk("lda_addr", err, 0);
      chk("lda_we_cnt", aw, M*M);
      chk("lda_no_mac", mv, 0);
`ifdef MVM_CTRL_CMD_ERR_EN
      chk("lda_cmd_err", ce, with_start ? 1 : 0);
`endif
   endtask

   // Cycle n is the n-th cycle after the edge that samples start.
   task automatic run_compute(input int ncyc);
      int addr_err = 0, data_err = 0, mv_cnt = 0, mv_first = -1, mf_cnt = 0;
      int ywe_cnt = 0, ywe_last = -1, done_cnt = 0, done_cyc = -1;
      int ov_cnt = 0, ov_first = -1, ov_last = -1;
      int ywe2_first = -1, ywe2_row = -1, done2_cyc = -1;
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (n <= M*M && (a_addr != 10'(n-1) || x_addr != 5'((n-1) % M))) addr_err++;
         if (mac_valid) begin
            mv_cnt++;
            if (mv_first < 0) mv_first = n;
         end
         if (mac_first) mf_cnt++;
         if (y_we) begin
            ywe_cnt++;
            ywe_last = n;
         end
         if (done) begin
            done_cnt++;
            done_cyc = n;
         end
         if (out_valid) begin
            if (ov_first < 0) ov_first = n;
            ov_last = n;
            if (ov_cnt < M && data_out != 32'(yexp[ov_cnt])) data_err++;
            ov_cnt++;
         end
         if (y_we2 && ywe2_first < 0) begin
            ywe2_first = n;
            ywe2_row   = int'(y_addr2);
         end
         if (done2) done2_cyc = n;
      end
      chk("cmp_issue_addr", addr_err, 0);
      chk("cmp_mv_first", mv_first, 2);
      chk("cmp_mv_cnt", mv_cnt, M*M);
      chk("cmp_mf_cnt", mf_cnt, M);
      chk("cmp_ywe_cnt", ywe_cnt, M);
      chk("cmp_ywe_last", ywe_last, 1026);
      chk("cmp_done_cyc", done_cyc, 1027);
      chk("cmp_done_cnt", done_cnt, 1);
      chk("cmp_ov_first", ov_first, 1028);
      chk("cmp_ov_last", ov_last, 1059);
      chk("cmp_ov_cnt", ov_cnt, M);
      chk("cmp_data", data_err, 0);
      chk("lat3_ywe_row0_cyc", ywe2_first, 36);
      chk("lat3_ywe_row0_addr", ywe2_row, 0);
      chk("lat3_done_cyc", done2_cyc, 1029);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", int'(outs1), 0);
      chk("rst_outs_lat3", int'(outs2), 0);
      @(posedge clk) #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_outs", int'(outs1), 0);

      // x = k, with a start pulse during the load that must be ignored
      load_x(1'b1);
      // A = identity -> y[j] = j
      load_a(0, 1'b0);
      for (int j = 0; j < M; j++) yexp[j] = j;
      run_compute(1070);

      // loadMatrix and start together: load wins (A = all ones)
      load_a(1, 1'b1);

      // reset in the middle of row 10, then a full clean run
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      repeat (330) @(negedge clk);
      chk("mid_a_addr", int'(a_addr), 329);
      reset = 1'b1;
      #1;
      chk("mid_rst_outs", int'(outs1), 0);
      chk("mid_rst_outs_lat3", int'(outs2), 0);
      @(negedge clk);
      chk("mid_rst_hold", int'(outs1), 0);
      @(posedge clk) #1 reset = 1'b0;
      // all-ones A, x = k -> y[j] = 0+1+...+31 = 496
      for (int j = 0; j < M; j++) yexp[j] = 496;
      run_compute(1070);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
